bitstream_scan_ctrl: RTL and testbench

- Serializes parallel words MSB-first through an embedded, enable-gated Mealy detector for the overlapping pattern 1101.
- Counts detections per word and returns the count on a valid/ready output port.
- Sits between a word-oriented producer and the serial 1101 detection datapath, and schedules when that datapath advances.

---
 rtl/bitstream_scan_ctrl_if.sv | 22 ++
 rtl/bitstream_scan_ctrl.sv | 103 ++++++++++
 tb/tb_bitstream_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitstream_scan_ctrl_if.sv
// Word-in / count-out handshake bundle for bitstream_scan_ctrl.
interface bitstream_scan_ctrl_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );
endinterface

// File: rtl/bitstream_scan_ctrl.sv
// Serializes words MSB-first through an overlapping 1101 Mealy detector
// and reports the saturating per-word hit count over a valid/ready port.
module bitstream_scan_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned CW    = 4,
  parameter int unsigned CARRY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bitstream_scan_ctrl_if.slave bus,
  input  logic                 flush,
  output logic                 hit,
  output logic                 busy
);
  localparam int unsigned BW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctrl_t;
  typedef enum logic [1:0] {S0, S1, S2, S3} det_t;

  ctrl_t         state;
  det_t          det;
  det_t          det_next;
  logic [W-1:0]  sreg;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] count;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          b;

  assign b             = sreg[W-1];
  assign hit           = (state == SHIFT) && (det == S3) && b;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = count;
  assign busy          = busy_q;

  // Overlapping 1101: a hit leaves the trailing '1' as the start of the next match.
  always_comb begin
    det_next = S0;
    case (det)
      S0: det_next = b ? S1 : S0;
      S1: det_next = b ? S2 : S0;
      S2: det_next = b ? S2 : S3;
      S3: det_next = b ? S1 : S0;
      default: det_next = S0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      det         <= S0;
      sreg        <= '0;
      bit_cnt     <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sreg       <= bus.in_data;
            bit_cnt    <= BW'(W - 1);
            count      <= '0;
            state      <= SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          sreg <= {sreg[W-2:0], 1'b0};
          if (hit && (count != {CW{1'b1}}))
            count <= count + 1'b1;
          if (bit_cnt == '0) begin
            state       <= REPORT;
            out_valid_q <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        REPORT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Flush overrides everything but does not suppress this cycle's hit.
      if (flush)
        det <= S0;
      else if ((state == IDLE) && bus.in_valid && in_ready_q && (CARRY == 0))
        det <= S0;
      else if (state == SHIFT)
        det <= det_next;
    end
  end
endmodule

// File: tb/tb_bitstream_scan_ctrl.sv
// Directed bench: three parameterizations share muxed stimulus; a history-based
// 1101 model fills a count scoreboard and per-bit hit masks.
module tb_bitstream_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int          sel;
  logic        in_valid_x, out_ready_x, flush_x;
  logic [15:0] in_data_x;

  bitstream_scan_ctrl_if #(.W(8),  .CW(4)) a_if ();
  bitstream_scan_ctrl_if #(.W(8),  .CW(4)) b_if ();
  bitstream_scan_ctrl_if #(.W(16), .CW(2)) c_if ();
  logic hit_a, hit_b, hit_c, busy_a, busy_b, busy_c;

  assign a_if.in_valid  = in_valid_x && (sel == 0);
  assign b_if.in_valid  = in_valid_x && (sel == 1);
  assign c_if.in_valid  = in_valid_x && (sel == 2);
  assign a_if.in_data   = in_data_x[7:0];
  assign b_if.in_data   = in_data_x[7:0];
  assign c_if.in_data   = in_data_x;
  assign a_if.out_ready = out_ready_x && (sel == 0);
  assign b_if.out_ready = out_ready_x && (sel == 1);
  assign c_if.out_ready = out_ready_x && (sel == 2);

  bitstream_scan_ctrl #(.W(8), .CW(4), .CARRY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .flush(flush_x && (sel == 0)), .hit(hit_a), .busy(busy_a));
  bitstream_scan_ctrl #(.W(8), .CW(4), .CARRY(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .flush(flush_x && (sel == 1)), .hit(hit_b), .busy(busy_b));
  bitstream_scan_ctrl #(.W(16), .CW(2), .CARRY(1)) dut_c (
    .clk(clk), .rst(rst), .bus(c_if), .flush(flush_x && (sel == 2)), .hit(hit_c), .busy(busy_c));

  logic        in_ready_s, out_valid_s, hit_s, busy_s;
  logic [15:0] out_count_s;
  always_comb begin
    in_ready_s  = a_if.in_ready;
    out_valid_s = a_if.out_valid;
    out_count_s = {12'd0, a_if.out_count};
    hit_s       = hit_a;
    busy_s      = busy_a;
    if (sel == 1) begin
      in_ready_s  = b_if.in_ready;
      out_valid_s = b_if.out_valid;
      out_count_s = {12'd0, b_if.out_count};
      hit_s       = hit_b;
      busy_s      = busy_b;
    end else if (sel == 2) begin
      in_ready_s  = c_if.in_ready;
      out_valid_s = c_if.out_valid;
      out_count_s = {14'd0, c_if.out_count};
      hit_s       = hit_c;
      busy_s      = busy_c;
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  int          last_exp;
  logic [15:0] exp_mask;
  int          hist_m[3];
  int          len_m[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a hit is a 1 arriving right after a tracked "110" suffix.
  function automatic void model(input logic [15:0] word, input int w, input int maxc,
                                input int flush_i, inout int hist, inout int len,
                                output int cnt, output logic [15:0] mask);
    logic bb;
    cnt  = 0;
    mask = '0;
    for (int i = 0; i < w; i++) begin
      bb = word[w-1-i];
      if (len >= 3 && (hist & 7) == 6 && bb) begin
        mask[w-1-i] = 1'b1;
        if (cnt < maxc) cnt++;
      end
      hist = ((hist << 1) | int'(bb)) & 15;
      len  = (len < 4) ? len + 1 : 4;
      if (i == flush_i) begin
        hist = 0;
        len  = 0;
      end
    end
  endfunction

  function automatic int cur_w();
    return (sel == 2) ? 16 : 8;
  endfunction

  task automatic load_word(input logic [15:0] word, input int flush_i);
    int n, cnt, h, l;
    logic [15:0] m;
    h = hist_m[sel];
    l = len_m[sel];
    if (sel == 1) begin
      h = 0;
      l = 0;
    end
    model(word, cur_w(), (sel == 2) ? 3 : 15, flush_i, h, l, cnt, m);
    hist_m[sel] = h;
    len_m[sel]  = l;
    exp_q.push_back(cnt);
    exp_mask   = m;
    in_data_x  = word;
    in_valid_x = 1'b1;
    n = 0;
    while (!in_ready_s && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("load_ready", 32'(in_ready_s), 32'd1);
    @(negedge clk);
    in_valid_x = 1'b0;
  endtask

  task automatic scan_word(input int flush_i);
    for (int i = 0; i < cur_w(); i++) begin
      check($sformatf("hit_bit%0d", i), 32'(hit_s), 32'(exp_mask[cur_w()-1-i]));
      check("busy_shift", 32'(busy_s), 32'd1);
      flush_x = (i == flush_i);
      @(negedge clk);
    end
    flush_x = 1'b0;
    check("out_valid_rise", 32'(out_valid_s), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      last_exp = 0;
    end else begin
      last_exp = exp_q.pop_front();
    end
    check("out_count", 32'(out_count_s), 32'(last_exp));
  endtask

  task automatic drain();
    out_ready_x = 1'b1;
    @(negedge clk);
    out_ready_x = 1'b0;
    check("idle_out_valid", 32'(out_valid_s), 32'd0);
    check("idle_in_ready", 32'(in_ready_s), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready_s),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid_s), 32'd0);
    check({tag, "_out_count"}, 32'(out_count_s), 32'd0);
    check({tag, "_hit"},       32'(hit_s),       32'd0);
    check({tag, "_busy"},      32'(busy_s),      32'd0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 0;
    in_valid_x = 1'b0;
    out_ready_x = 1'b0;
    flush_x = 1'b0;
    in_data_x = '0;
    for (int k = 0; k < 3; k++) begin
      hist_m[k] = 0;
      len_m[k]  = 0;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 0xDD: hits on SHIFT cycles 4 and 8, count 2
    load_word(16'h00DD, -1);
    scan_word(-1);
    check("dd_count_const", 32'(out_count_s), 32'd2);
    drain();

    // Backpressure with the next word already offered
    load_word(16'h00DD, -1);
    scan_word(-1);
    in_data_x  = 16'h006D;
    in_valid_x = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid_s), 32'd1);
      check("bp_out_count", 32'(out_count_s), 32'(last_exp));
      check("bp_in_ready", 32'(in_ready_s), 32'd0);
      @(negedge clk);
    end
    out_ready_x = 1'b1;
    @(negedge clk);
    out_ready_x = 1'b0;
    check("bp_idle_in_ready", 32'(in_ready_s), 32'd1);
    check("bp_idle_out_valid", 32'(out_valid_s), 32'd0);
    check("bp_idle_busy", 32'(busy_s), 32'd0);

    // 0x6D loads on the edge closing that single IDLE cycle
    load_word(16'h006D, -1);
    scan_word(-1);
    check("6d_count_const", 32'(out_count_s), 32'd2);
    drain();

    // Cross-word carry, CARRY=1
    load_word(16'h000E, -1);
    scan_word(-1);
    drain();
    load_word(16'h0080, -1);
    scan_word(-1);
    check("carry1_count_const", 32'(out_count_s), 32'd1);
    drain();

    // Reset after three bits of 0xDD
    load_word(16'h00DD, -1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midshift_rst");
    void'(exp_q.pop_back());
    hist_m[0] = 0;
    len_m[0]  = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Flush on the 3rd SHIFT cycle drops the leading 1101
    load_word(16'h00DD, 2);
    scan_word(2);
    check("flush_count_const", 32'(out_count_s), 32'd1);
    drain();

    // CARRY=0 clears history between words
    sel = 1;
    @(negedge clk);
    load_word(16'h000E, -1);
    scan_word(-1);
    drain();
    load_word(16'h0080, -1);
    scan_word(-1);
    check("carry0_count_const", 32'(out_count_s), 32'd0);
    drain();

    // Saturation: five hits into a 2-bit counter
    sel = 2;
    @(negedge clk);
    load_word(16'hDB6D, -1);
    scan_word(-1);
    check("sat_count_const", 32'(out_count_s), 32'd3);
    drain();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
